mem_arbiter: RTL and testbench

Two-port arbiter and sequencer for the single synchronous data memory port shared by the processor datapath (fetch/ld/st) and a second requester (loader/DMA or I/O engine).
- Accepts word read/write requests over a req/ack handshake and grants one requester at a time, round-robin.
- Drives memory address, write data and write enable from registered copies of the granted request.
- Returns read data after the memory's fixed read latency.

---
 rtl/mem_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_arbiter.sv | 456 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter and sequencer sharing one synchronous memory port between two
// requesters; one transaction in flight at a time (IDLE -> ISSUE -> [WAIT] -> RESP).
module mem_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int READ_LAT = 1
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              ack0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_dout,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q,
  output logic [1:0]        dbg_state
);

  // Handshake: a requester raises reqN with weN/addrN/wdataN and keeps them until ackN.
  // The fields are captured at grant, so later changes (or dropping req) cannot disturb
  // the transaction; ackN is a single-cycle completion pulse, with rdata valid for reads.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [2:0] LAT = 3'(READ_LAT);

  state_t     state;
  logic       last_grant;
  logic       sel;
  logic       we_q;
  logic [2:0] wait_cnt;
  logic       pick1;

  assign dbg_state = state;

  // On a tie the requester that was not served last wins.
  always_comb begin
    pick1 = req1;
    if (req0 && req1) pick1 = ~last_grant;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      sel        <= 1'b0;
      we_q       <= 1'b0;
      wait_cnt   <= 3'd0;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      busy       <= 1'b0;
      rdata      <= '0;
      mem_addr   <= '0;
      mem_dout   <= '0;
      mem_wren   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          mem_wren <= 1'b0;
          if (req0 || req1) begin
            sel        <= pick1;
            last_grant <= pick1;
            gnt0       <= ~pick1;
            gnt1       <= pick1;
            busy       <= 1'b1;
            mem_addr   <= pick1 ? addr1 : addr0;
            mem_dout   <= pick1 ? wdata1 : wdata0;
            mem_wren   <= pick1 ? we1 : we0;
            we_q       <= pick1 ? we1 : we0;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          mem_wren <= 1'b0;
          wait_cnt <= LAT;
          if (we_q) begin
            ack0  <= ~sel;
            ack1  <= sel;
            state <= RESP;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          // Counter holds the number of cycles left until mem_q carries the read word.
          if (wait_cnt == 3'd1) begin
            rdata <= mem_q;
            ack0  <= ~sel;
            ack1  <= sel;
            state <= RESP;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        RESP: begin
          ack0  <= 1'b0;
          ack1  <= 1'b0;
          gnt0  <= 1'b0;
          gnt1  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus a randomized two-requester stream,
// run against a READ_LAT=1 instance (dut) and a READ_LAT=3 instance (dut3).
module tb_mem_arbiter;

  logic        clock;
  logic        resetn;
  logic        req0, we0, req1, we1;
  logic [15:0] addr0, wdata0, addr1, wdata1;

  logic        gnt0, ack0, gnt1, ack1, busy, mem_wren;
  logic [15:0] rdata, mem_addr, mem_dout, mem_q;
  logic [1:0]  dbg_state;

  logic        gnt0_3, ack0_3, gnt1_3, ack1_3, busy_3, mem_wren_3;
  logic [15:0] rdata_3, mem_addr_3, mem_dout_3, mem_q_3;
  logic [1:0]  dbg_state_3;

  int n_checks;
  int n_fail;

  logic [31:0] exp_q[$];
  logic [15:0] ref_mem [0:65535];

  logic [15:0] mem_a [0:65535];
  logic [15:0] mem_b [0:65535];
  logic [15:0] pipe_b [0:2];
  logic        pre_en;
  logic [15:0] pre_addr, pre_data;

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .READ_LAT(1)) dut (
    .clock(clock), .resetn(resetn),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .gnt0(gnt0), .ack0(ack0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .gnt1(gnt1), .ack1(ack1),
    .rdata(rdata), .busy(busy), .mem_addr(mem_addr), .mem_dout(mem_dout),
    .mem_wren(mem_wren), .mem_q(mem_q), .dbg_state(dbg_state)
  );

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .READ_LAT(3)) dut3 (
    .clock(clock), .resetn(resetn),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .gnt0(gnt0_3), .ack0(ack0_3),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .gnt1(gnt1_3), .ack1(ack1_3),
    .rdata(rdata_3), .busy(busy_3), .mem_addr(mem_addr_3), .mem_dout(mem_dout_3),
    .mem_wren(mem_wren_3), .mem_q(mem_q_3), .dbg_state(dbg_state_3)
  );

  // ---------------- clock / memories ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Synchronous memories: mem_a has 1-cycle read latency, mem_b 3 cycles; old data on read-during-write.
  always @(posedge clock) begin
    mem_q     <= mem_a[mem_addr];
    pipe_b[0] <= mem_b[mem_addr_3];
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
    if (mem_wren)   mem_a[mem_addr]   <= mem_dout;
    if (mem_wren_3) mem_b[mem_addr_3] <= mem_dout_3;
    if (pre_en) begin
      mem_a[pre_addr] <= pre_data;
      mem_b[pre_addr] <= pre_data;
    end
  end
  assign mem_q_3 = pipe_b[2];

  always @(negedge clock) begin
    if (resetn) begin
      n_checks++;
      if ((gnt0 && gnt1) || (ack0 && ack1) || (gnt0_3 && gnt1_3) || (ack0_3 && ack1_3)) begin
        n_fail++;
        $display("FAIL exclusive: gnt=%b%b ack=%b%b gnt_3=%b%b ack_3=%b%b, required at most one high per pair",
                 gnt0, gnt1, ack0, ack1, gnt0_3, gnt1_3, ack0_3, ack1_3);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic preload(input logic [15:0] a, input logic [15:0] d);
    pre_addr = a;
    pre_data = d;
    pre_en   = 1'b1;
    @(negedge clock);
    pre_en     = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic do_reset();
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
    resetn = 1'b0;
    repeat (2) @(negedge clock);
    resetn = 1'b1;
  endtask

  task automatic drive_req(input int i, input logic r, input logic we, input logic [15:0] a,
                           input logic [15:0] d);
    if (i == 0) begin
      req0 = r; we0 = we; addr0 = a; wdata0 = d;
    end else begin
      req1 = r; we1 = we; addr1 = a; wdata1 = d;
    end
  endtask

  task automatic read0(input logic [15:0] a, output logic [15:0] d, output logic ok);
    req0 = 1'b1; we0 = 1'b0; addr0 = a;
    ok = 1'b0;
    d  = '0;
    for (int t = 0; t < 10 && !ok; t++) begin
      @(negedge clock);
      if (ack0) begin
        ok = 1'b1;
        d  = rdata;
      end
    end
    req0 = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [53:0] v;
    @(negedge clock);
    v = {gnt0, gnt1, ack0, ack1, busy, mem_wren, mem_addr, mem_dout, rdata};
    n_checks++;
    if (v !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h, required 0", v); end
    req0 = 1'b1; we0 = 1'b1; addr0 = 16'hFFFF; wdata0 = 16'hFFFF;
    repeat (2) @(negedge clock);
    v = {gnt0_3, gnt1_3, ack0_3, ack1_3, busy_3, mem_wren_3, mem_addr_3, mem_dout_3, rdata_3};
    n_checks++;
    if (v !== '0) begin n_fail++; $display("FAIL reset_hold_dut3: got %h, required 0", v); end
    v = {gnt0, gnt1, ack0, ack1, busy, mem_wren, mem_addr, mem_dout, rdata};
    n_checks++;
    if (v !== '0) begin n_fail++; $display("FAIL reset_hold: got %h, required 0", v); end
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    resetn = 1'b1;
    @(negedge clock);
    n_checks++;
    if ({busy, gnt0, gnt1} !== 3'b000) begin
      n_fail++; $display("FAIL idle_after_reset: busy/gnt0/gnt1=%b, required 000", {busy, gnt0, gnt1});
    end
  endtask

  task automatic test_read_basic();
    preload(16'h0010, 16'h1234);
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0010;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clock);
      n_checks++;
      if ({gnt0, ack0, gnt1, ack1, busy} !== {1'b1, 1'(k == 3), 1'b0, 1'b0, 1'b1}) begin
        n_fail++;
        $display("FAIL read_basic_k%0d: gnt0/ack0/gnt1/ack1/busy=%b, required %b", k,
                 {gnt0, ack0, gnt1, ack1, busy}, {1'b1, 1'(k == 3), 3'b001});
      end
      if (k == 3) begin
        n_checks++;
        if (rdata !== 16'h1234) begin n_fail++; $display("FAIL read_basic_rdata: got %h, required 1234", rdata); end
        req0 = 1'b0;
      end
    end
    @(negedge clock);
    n_checks++;
    if ({gnt0, ack0, busy} !== 3'b000) begin
      n_fail++; $display("FAIL read_basic_end: gnt0/ack0/busy=%b, required 000", {gnt0, ack0, busy});
    end
  endtask

  task automatic test_write_basic();
    logic [15:0] d;
    logic        ok;
    req1 = 1'b1; we1 = 1'b1; addr1 = 16'h0020; wdata1 = 16'hBEEF;
    @(negedge clock);
    n_checks++;
    if ({mem_wren, mem_addr, mem_dout, gnt1, ack1} !== {1'b1, 16'h0020, 16'hBEEF, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL write_issue: wren=%b addr=%h dout=%h gnt1=%b ack1=%b, required 1 0020 beef 1 0",
               mem_wren, mem_addr, mem_dout, gnt1, ack1);
    end
    @(negedge clock);
    n_checks++;
    if ({mem_wren, ack1, ack0} !== 3'b010) begin
      n_fail++; $display("FAIL write_ack: wren/ack1/ack0=%b, required 010", {mem_wren, ack1, ack0});
    end
    req1 = 1'b0; we1 = 1'b0;
    @(negedge clock);
    n_checks++;
    if ({ack1, gnt1, mem_wren} !== 3'b000) begin
      n_fail++; $display("FAIL write_done: ack1/gnt1/wren=%b, required 000", {ack1, gnt1, mem_wren});
    end
    read0(16'h0020, d, ok);
    n_checks++;
    if (!ok || d !== 16'hBEEF) begin
      n_fail++; $display("FAIL write_readback: ack=%b data=%h, required 1 beef", ok, d);
    end
  endtask

  task automatic test_simultaneous();
    logic [3:0] exp_t [5];
    exp_t[0] = 4'b1000; exp_t[1] = 4'b1100; exp_t[2] = 4'b0000;
    exp_t[3] = 4'b0010; exp_t[4] = 4'b0011;
    do_reset();
    req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0030; wdata0 = 16'h1111;
    req1 = 1'b1; we1 = 1'b1; addr1 = 16'h0031; wdata1 = 16'h2222;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clock);
      n_checks++;
      if ({gnt0, ack0, gnt1, ack1} !== exp_t[k-1]) begin
        n_fail++;
        $display("FAIL simult_k%0d: gnt0/ack0/gnt1/ack1=%b, required %b", k, {gnt0, ack0, gnt1, ack1}, exp_t[k-1]);
      end
      if (k == 1 || k == 4) begin
        n_checks++;
        if ({mem_addr, mem_dout} !== ((k == 1) ? {16'h0030, 16'h1111} : {16'h0031, 16'h2222})) begin
          n_fail++; $display("FAIL simult_addr_k%0d: addr=%h dout=%h", k, mem_addr, mem_dout);
        end
      end
      if (k == 2) req0 = 1'b0;
      if (k == 5) req1 = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    int          t;
    int          acks;
    logic [31:0] e;
    logic [31:0] got;
    do_reset();
    preload(16'h0040, 16'hA0A0);
    preload(16'h0041, 16'h5151);
    exp_q.delete();
    for (int k = 0; k < 6; k++)
      exp_q.push_back({8'(3 + 4 * k), 7'd0, 1'(k % 2), (k % 2 == 0) ? 16'hA0A0 : 16'h5151});
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0040;
    req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0041;
    t = 0;
    acks = 0;
    while (acks < 6 && t < 40) begin
      @(negedge clock);
      t++;
      if (ack0 || ack1) begin
        acks++;
        got = {8'(t), 7'd0, ack1, rdata};
        e = '1;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        n_checks++;
        if (got !== e) begin
          n_fail++;
          $display("FAIL b2b_ack%0d: cycle/owner/data=%0d/%0d/%h, required %0d/%0d/%h", acks,
                   got[31:24], got[16], got[15:0], e[31:24], e[16], e[15:0]);
        end
        if (acks == 6) begin req0 = 1'b0; req1 = 1'b0; end
      end
    end
    n_checks++;
    if (acks != 6) begin n_fail++; $display("FAIL b2b_count: got %0d acks, required 6", acks); end
    req0 = 1'b0; req1 = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [53:0] v;
    do_reset();
    preload(16'h0050, 16'h7777);
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0050;
    repeat (2) @(negedge clock);
    n_checks++;
    if ({busy, gnt0, ack0} !== 3'b110) begin
      n_fail++; $display("FAIL mid_pre: busy/gnt0/ack0=%b, required 110", {busy, gnt0, ack0});
    end
    #2 resetn = 1'b0;
    #1;
    v = {gnt0, gnt1, ack0, ack1, busy, mem_wren, mem_addr, mem_dout, rdata};
    n_checks++;
    if (v !== '0) begin n_fail++; $display("FAIL mid_reset: got %h, required 0", v); end
    v = {gnt0_3, gnt1_3, ack0_3, ack1_3, busy_3, mem_wren_3, mem_addr_3, mem_dout_3, rdata_3};
    n_checks++;
    if (v !== '0) begin n_fail++; $display("FAIL mid_reset_dut3: got %h, required 0", v); end
    @(negedge clock);
    n_checks++;
    if ({ack0, gnt0} !== 2'b00) begin
      n_fail++; $display("FAIL mid_no_ack: ack0/gnt0=%b, required 00", {ack0, gnt0});
    end
    resetn = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clock);
      n_checks++;
      if ({gnt0, ack0} !== {1'b1, 1'(k == 3)}) begin
        n_fail++; $display("FAIL mid_restart_k%0d: gnt0/ack0=%b, required %b", k, {gnt0, ack0}, {1'b1, 1'(k == 3)});
      end
      if (k == 3) begin
        n_checks++;
        if (rdata !== 16'h7777) begin n_fail++; $display("FAIL mid_rdata: got %h, required 7777", rdata); end
        req0 = 1'b0;
      end
    end
  endtask

  task automatic test_read_lat3();
    do_reset();
    preload(16'h0060, 16'h5A5A);
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0060;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clock);
      n_checks++;
      if ({gnt0_3, ack0_3, gnt1_3, ack1_3} !== {1'b1, 1'(k == 5), 2'b00}) begin
        n_fail++;
        $display("FAIL lat3_k%0d: gnt0/ack0/gnt1/ack1=%b, required %b", k,
                 {gnt0_3, ack0_3, gnt1_3, ack1_3}, {1'b1, 1'(k == 5), 2'b00});
      end
      if (k == 5) begin
        n_checks++;
        if (rdata_3 !== 16'h5A5A) begin n_fail++; $display("FAIL lat3_rdata: got %h, required 5a5a", rdata_3); end
        req0 = 1'b0;
      end
    end
  endtask

  task automatic test_write_drop();
    logic [15:0] d;
    logic        ok;
    do_reset();
    req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0070; wdata0 = 16'hC0DE;
    @(negedge clock);
    n_checks++;
    if ({mem_wren, mem_addr, mem_dout, gnt0} !== {1'b1, 16'h0070, 16'hC0DE, 1'b1}) begin
      n_fail++; $display("FAIL drop_issue: wren=%b addr=%h dout=%h gnt0=%b, required 1 0070 c0de 1",
                         mem_wren, mem_addr, mem_dout, gnt0);
    end
    req0 = 1'b0; we0 = 1'b0; addr0 = 16'h0071; wdata0 = 16'hFFFF;
    @(negedge clock);
    n_checks++;
    if ({ack0, gnt0, mem_wren} !== 3'b110) begin
      n_fail++; $display("FAIL drop_ack: ack0/gnt0/wren=%b, required 110", {ack0, gnt0, mem_wren});
    end
    @(negedge clock);
    n_checks++;
    if (mem_a[16'h0070] !== 16'hC0DE || ack0 !== 1'b0) begin
      n_fail++; $display("FAIL drop_commit: mem[0070]=%h ack0=%b, required c0de 0", mem_a[16'h0070], ack0);
    end
    read0(16'h0070, d, ok);
    n_checks++;
    if (!ok || d !== 16'hC0DE) begin n_fail++; $display("FAIL drop_readback: ack=%b data=%h, required 1 c0de", ok, d); end
  endtask

  task automatic test_random();
    logic        act [2];
    logic        t_we [2];
    logic [15:0] t_addr [2];
    logic [15:0] t_data [2];
    int          left [2];
    int          gap [2];
    int          gnt_t [2];
    logic        pg0, pg1, pr0, pr1, last_srv, w, exp_w;
    int          t, acks;
    logic [31:0] e;
    do_reset();
    for (int i = 0; i < 16; i++) preload(16'h0100 + 16'(i), 16'($urandom));
    for (int i = 0; i < 2; i++) begin
      act[i] = 1'b0; t_we[i] = 1'b0; t_addr[i] = '0; t_data[i] = '0;
      left[i] = 20; gap[i] = int'($urandom_range(0, 3)); gnt_t[i] = 0;
    end
    exp_q.delete();
    pg0 = 1'b0; pg1 = 1'b0; last_srv = 1'b1;
    t = 0;
    acks = 0;
    while ((left[0] > 0 || left[1] > 0 || act[0] || act[1]) && t < 3000) begin
      @(negedge clock);
      t++;
      pr0 = req0;
      pr1 = req1;
      if ((gnt0 && !pg0) || (gnt1 && !pg1)) begin
        w = gnt1;
        exp_w = (pr0 && pr1) ? ~last_srv : pr1;
        n_checks++;
        if (!(pr0 || pr1) || w !== exp_w) begin
          n_fail++;
          $display("FAIL rand_grant: t=%0d granted %0d, required %0d (req0=%b req1=%b)", t, w, exp_w, pr0, pr1);
        end
        last_srv = exp_w;
        gnt_t[w] = t;
        if (t_we[w]) ref_mem[t_addr[w]] = t_data[w];
        else exp_q.push_back({16'h0, ref_mem[t_addr[w]]});
      end
      pg0 = gnt0;
      pg1 = gnt1;
      if (ack0 || ack1) begin
        w = ack1;
        acks++;
        n_checks++;
        if (!act[w] || (t - gnt_t[w]) != (t_we[w] ? 1 : 2)) begin
          n_fail++;
          $display("FAIL rand_latency: t=%0d req%0d active=%b gnt-to-ack=%0d, required %0d", t, w, act[w],
                   t - gnt_t[w], t_we[w] ? 1 : 2);
        end
        if (!t_we[w]) begin
          e = '1;
          if (exp_q.size() > 0) e = exp_q.pop_front();
          n_checks++;
          if (rdata !== e[15:0]) begin
            n_fail++; $display("FAIL rand_rdata: t=%0d addr=%h got %h, required %h", t, t_addr[w], rdata, e[15:0]);
          end
        end
        act[w] = 1'b0;
        gap[w] = int'($urandom_range(0, 3));
        drive_req(int'(w), 1'b0, 1'b0, t_addr[w], t_data[w]);
      end
      for (int i = 0; i < 2; i++) begin
        if (!act[i] && left[i] > 0) begin
          if (gap[i] == 0) begin
            t_we[i]   = 1'($urandom_range(0, 1));
            t_addr[i] = 16'h0100 + 16'($urandom_range(0, 15));
            t_data[i] = 16'($urandom);
            act[i]    = 1'b1;
            left[i]--;
            drive_req(i, 1'b1, t_we[i], t_addr[i], t_data[i]);
          end else begin
            gap[i]--;
          end
        end
      end
    end
    n_checks++;
    if (acks != 40 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL rand_complete: %0d acks, %0d reads unanswered, required 40 and 0", acks, exp_q.size());
    end
    req0 = 1'b0; req1 = 1'b0;
  endtask

  // ---------------- main sequence / report ----------------
  initial begin
    n_checks = 0;
    n_fail   = 0;
    pre_en = 1'b0; pre_addr = '0; pre_data = '0;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
    resetn = 1'b1;
    #1 resetn = 1'b0;
    test_reset();
    test_read_basic();
    test_write_basic();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid();
    test_read_lat3();
    test_write_drop();
    test_random();
    repeat (2) @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached before the end of the sequence");
    $fatal(1);
  end

endmodule
